// File: rtl/float_triple_packer_if.sv
// float_triple_packer_if: value stream in, triple issue out toward the sorter.
// FLEN is the global float width (64 unless defined beforehand).
`ifndef FLEN
`define FLEN 64
`endif
interface float_triple_packer_if;
   logic                   in_valid;
   logic                   in_ready;
   logic [`FLEN-1:0]       in_data;
   logic                   flush;
   logic                   sort_valid_in;
   logic [0:2][`FLEN-1:0]  sort_unsorted;
   logic                   sort_busy;
   modport master (output in_valid, in_data, flush, sort_busy,
                   input  in_ready, sort_valid_in, sort_unsorted);
   modport slave  (input  in_valid, in_data, flush, sort_busy,
                   output in_ready, sort_valid_in, sort_unsorted);
endinterface

// File: rtl/float_triple_packer.sv
// float_triple_packer: groups a float stream into triples and issues them to the sorter when idle.
// Define FLOAT_TRIPLE_PACKER_FLUSH_EN to let flush pad a partial triple with PAD_VALUE.
`ifndef FLEN
`define FLEN 64
`endif
module float_triple_packer #(
   parameter int          CNT_W     = 16,
   parameter logic [63:0] PAD_VALUE = 64'h7FF0_0000_0000_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   float_triple_packer_if.slave bus,
   output logic [CNT_W-1:0]     issued_cnt
);
   localparam int FLEN = `FLEN;
   logic [0:2][FLEN-1:0] col, col_nxt, hold;
   logic [1:0]           cnt, cnt_nxt;
   logic                 hold_full, accept, issue, xfer;
   assign bus.in_ready      = cnt != 2'd3;
   assign accept            = bus.in_valid && bus.in_ready;
   assign issue             = hold_full && !bus.sort_busy;
   assign xfer              = cnt == 2'd3 && (!hold_full || issue);
   assign bus.sort_valid_in = issue;
   assign bus.sort_unsorted = hold;
   always_comb begin
      col_nxt = col;
      for (int i = 0; i < 3; i++) col_nxt[i] = accept && cnt == 2'(i) ? bus.in_data : col[i];
      cnt_nxt = cnt + {1'b0, accept};
`ifdef FLOAT_TRIPLE_PACKER_FLUSH_EN
      if (bus.flush && (cnt_nxt == 2'd1 || cnt_nxt == 2'd2)) begin
         for (int i = 1; i < 3; i++) if (2'(i) >= cnt_nxt) col_nxt[i] = PAD_VALUE[FLEN-1:0];
         cnt_nxt = 2'd3;
      end
`endif
   end
`ifndef FLOAT_TRIPLE_PACKER_FLUSH_EN
   logic [64:0] unused_flush;
   assign unused_flush = {bus.flush, PAD_VALUE};
`endif
   // A transfer in an issue cycle overwrites hold only after the sorter has sampled it.
   always_ff @(posedge clk)
      if (rst) begin
         col        <= '0;
         hold       <= '0;
         cnt        <= '0;
         hold_full  <= 1'b0;
         issued_cnt <= '0;
      end else begin
         issued_cnt <= issued_cnt + CNT_W'(issue);
         if (xfer) begin
            hold      <= col;
            hold_full <= 1'b1;
            cnt       <= '0;
         end else begin
            col <= col_nxt;
            cnt <= cnt_nxt;
            if (issue) hold_full <= 1'b0;
         end
      end
endmodule

// File: tb/tb_float_triple_packer.sv
// tb_float_triple_packer: randomized stream against a triple-grouping queue model and sorter busy model.
`ifndef FLEN
`define FLEN 64
`endif
module tb_float_triple_packer;
   localparam int FLEN  = `FLEN;
   localparam int CNT_W = 4;
   typedef logic [0:2][FLEN-1:0] trip_t;
   localparam logic [FLEN-1:0] PAD = 64'h7FF0_0000_0000_0000;
   localparam logic [FLEN-1:0] F1  = 64'h3FF0_0000_0000_0000;
   localparam logic [FLEN-1:0] F2  = 64'h4000_0000_0000_0000;
   localparam logic [FLEN-1:0] F3  = 64'h4008_0000_0000_0000;
   localparam logic [FLEN-1:0] F5  = 64'h4014_0000_0000_0000;
   localparam logic [FLEN-1:0] F6  = 64'h4018_0000_0000_0000;
   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [CNT_W-1:0] issued_cnt;
   float_triple_packer_if bus();
   float_triple_packer #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus), .issued_cnt(issued_cnt));
   always #5 clk = ~clk;
   int n_cmp = 0, n_err = 0, cyc = 0, n_acc = 0, n_iss = 0;
   int third_cyc = -1, last_iss = -1, busy_left = 0, gap = 0;
   bit force_busy = 0, flush_drv = 0, obs_rdy = 0, exp_rdy = 0, third_now = 0;
   logic [FLEN-1:0] src[$];
   logic [FLEN-1:0] pend[$];
   trip_t           exp_q[$];
   trip_t           last_uns;

   // One clock: drive, sample at negedge, update the model, then step past the edge.
   task automatic cycle();
      bit acc, iss;
      bus.in_valid  = src.size() > 0 && $urandom_range(99) >= gap;
      bus.in_data   = src.size() > 0 ? src[0] : '0;
      bus.flush     = flush_drv;
      bus.sort_busy = force_busy || busy_left > 0;
      exp_rdy       = !third_now;
      @(negedge clk);
      acc       = bus.in_valid && bus.in_ready;
      iss       = bus.sort_valid_in;
      obs_rdy   = bus.in_ready;
      third_now = 0;
      if (rst) begin
         src.delete();
         pend.delete();
         exp_q.delete();
         iss = 0;
      end else begin
         if (acc) begin
            pend.push_back(src.pop_front());
            n_acc++;
         end
`ifdef FLOAT_TRIPLE_PACKER_FLUSH_EN
         if (flush_drv && pend.size() inside {[1:2]}) while (pend.size() < 3) pend.push_back(PAD);
`endif
         if (pend.size() == 3) begin
            exp_q.push_back({pend[0], pend[1], pend[2]});
            pend.delete();
            third_now = 1;
            third_cyc = cyc;
         end
         if (iss) begin
            n_iss++;
            last_iss = cyc;
            last_uns = bus.sort_unsorted;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL issue_unexpected: got %h, required no issue", bus.sort_unsorted);
            end else begin
               if (bus.sort_unsorted !== exp_q[0]) begin
                  n_err++;
                  $display("FAIL issue_order: got %h, required %h", bus.sort_unsorted, exp_q[0]);
               end
               void'(exp_q.pop_front());
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      busy_left = iss ? 3 : (busy_left > 0 ? busy_left - 1 : 0);
      flush_drv = 0;
   endtask

   task automatic drain(input int lim);
      int k = 0;
      while ((src.size() > 0 || exp_q.size() > 0) && k < lim) begin
         cycle();
         k++;
      end
      n_cmp++;
      if (src.size() > 0 || exp_q.size() > 0) begin
         n_err++;
         $display("FAIL drain_timeout: %0d values, %0d triples outstanding, required 0", src.size(), exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1;
      cycle();
      cycle();
      rst = 0;
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready); end
      n_cmp++; if (bus.sort_valid_in !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, required 0", bus.sort_valid_in); end
      n_cmp++; if (bus.sort_unsorted !== '0) begin n_err++; $display("FAIL reset_unsorted: got %h, required 0", bus.sort_unsorted); end
      n_cmp++; if (issued_cnt !== '0) begin n_err++; $display("FAIL reset_cnt: got %0d, required 0", issued_cnt); end
   endtask

   task automatic test_latency();
      trip_t want = {F3, F1, F2};
      gap = 0;
      src = {F3, F1, F2};
      drain(20);
      n_cmp++; if (last_iss - third_cyc != 2) begin n_err++; $display("FAIL latency: got %0d, required 2", last_iss - third_cyc); end
      n_cmp++; if (last_uns !== want) begin n_err++; $display("FAIL latency_data: got %h, required %h", last_uns, want); end
      n_cmp++; if (issued_cnt !== 4'd1) begin n_err++; $display("FAIL latency_cnt: got %0d, required 1", issued_cnt); end
   endtask

   task automatic test_stream();
      int a0 = n_acc, i0 = n_iss, k = 0;
      gap = 0;
      for (int i = 0; i < 12; i++) src.push_back({$urandom, $urandom});
      while (src.size() > 0 && k < 100) begin
         cycle();
         k++;
         n_cmp++;
         if (obs_rdy !== exp_rdy) begin n_err++; $display("FAIL stream_in_ready: cycle %0d got %b, required %b", cyc, obs_rdy, exp_rdy); end
      end
      drain(60);
      n_cmp++; if (n_iss - i0 != 4) begin n_err++; $display("FAIL stream_issues: got %0d, required 4", n_iss - i0); end
      n_cmp++; if (n_acc - a0 != 12) begin n_err++; $display("FAIL stream_accepts: got %0d, required 12", n_acc - a0); end
      n_cmp++; if (issued_cnt !== 4'd5) begin n_err++; $display("FAIL stream_cnt: got %0d, required 5", issued_cnt); end
   endtask

   task automatic test_backpressure();
      int a0 = n_acc, i0 = n_iss, k = 0;
      force_busy = 1;
      for (int i = 0; i < 7; i++) src.push_back({$urandom, $urandom});
      repeat (20) cycle();
      n_cmp++; if (n_acc - a0 != 6) begin n_err++; $display("FAIL bp_accepts: got %0d, required 6", n_acc - a0); end
      n_cmp++; if (obs_rdy !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b, required 0", obs_rdy); end
      n_cmp++; if (n_iss - i0 != 0) begin n_err++; $display("FAIL bp_issue_while_busy: got %0d, required 0", n_iss - i0); end
      force_busy = 0;
      while (n_iss - i0 < 2 && k < 40) begin
         cycle();
         k++;
      end
      n_cmp++; if (n_iss - i0 != 2) begin n_err++; $display("FAIL bp_release_issues: got %0d, required 2", n_iss - i0); end
      n_cmp++; if (n_acc - a0 != 7) begin n_err++; $display("FAIL bp_release_accepts: got %0d, required 7", n_acc - a0); end
      n_cmp++; if (obs_rdy !== 1'b1) begin n_err++; $display("FAIL bp_ready_after: got %b, required 1", obs_rdy); end
      n_cmp++; if (issued_cnt !== 4'd7) begin n_err++; $display("FAIL bp_cnt: got %0d, required 7", issued_cnt); end
   endtask

   task automatic test_flush();
      int a0, i0;
      rst = 1;
      cycle();
      rst = 0;
      a0 = n_acc;
      i0 = n_iss;
      src = {F5, F6};
      cycle();
      flush_drv = 1;
      cycle();
`ifdef FLOAT_TRIPLE_PACKER_FLUSH_EN
      begin
         trip_t want = {F5, F6, PAD};
         drain(20);
         n_cmp++; if (n_iss - i0 != 1) begin n_err++; $display("FAIL flush_issues: got %0d, required 1", n_iss - i0); end
         n_cmp++; if (last_uns !== want) begin n_err++; $display("FAIL flush_data: got %h, required %h", last_uns, want); end
         flush_drv = 1;
         cycle();
         repeat (8) cycle();
         n_cmp++; if (n_iss - i0 != 1) begin n_err++; $display("FAIL flush_empty: got %0d issues, required 1", n_iss - i0); end
         n_cmp++; if (issued_cnt !== 4'd1) begin n_err++; $display("FAIL flush_cnt: got %0d, required 1", issued_cnt); end
      end
`else
      repeat (10) cycle();
      n_cmp++; if (n_iss - i0 != 0) begin n_err++; $display("FAIL flush_ignored: got %0d issues, required 0", n_iss - i0); end
      n_cmp++; if (n_acc - a0 != 2) begin n_err++; $display("FAIL flush_accepts: got %0d, required 2", n_acc - a0); end
      n_cmp++; if (obs_rdy !== 1'b1) begin n_err++; $display("FAIL flush_in_ready: got %b, required 1", obs_rdy); end
      n_cmp++; if (issued_cnt !== 4'd0) begin n_err++; $display("FAIL flush_cnt: got %0d, required 0", issued_cnt); end
`endif
   endtask

   task automatic test_reset_mid();
      int a0, i0, k = 0;
      rst = 1;
      cycle();
      rst = 0;
      a0 = n_acc;
      force_busy = 1;
      for (int i = 0; i < 5; i++) src.push_back({$urandom, $urandom});
      while (src.size() > 0 && k < 30) begin
         cycle();
         k++;
      end
      n_cmp++; if (n_acc - a0 != 5) begin n_err++; $display("FAIL mid_accepts: got %0d, required 5", n_acc - a0); end
      force_busy = 0;
      rst = 1;
      cycle();
      rst = 0;
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL mid_in_ready: got %b, required 1", bus.in_ready); end
      n_cmp++; if (bus.sort_valid_in !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b, required 0", bus.sort_valid_in); end
      n_cmp++; if (bus.sort_unsorted !== '0) begin n_err++; $display("FAIL mid_unsorted: got %h, required 0", bus.sort_unsorted); end
      n_cmp++; if (issued_cnt !== '0) begin n_err++; $display("FAIL mid_cnt: got %0d, required 0", issued_cnt); end
      i0 = n_iss;
      repeat (10) cycle();
      n_cmp++; if (n_iss - i0 != 0) begin n_err++; $display("FAIL mid_stale_issue: got %0d, required 0", n_iss - i0); end
   endtask

   task automatic test_wrap();
      int i0 = n_iss;
      gap = 30;
      for (int i = 0; i < 45; i++) src.push_back({$urandom, $urandom});
      drain(800);
      n_cmp++; if (issued_cnt !== 4'd15) begin n_err++; $display("FAIL wrap_15: got %0d, required 15", issued_cnt); end
      for (int i = 0; i < 3; i++) src.push_back({$urandom, $urandom});
      drain(100);
      n_cmp++; if (issued_cnt !== 4'd0) begin n_err++; $display("FAIL wrap_0: got %0d, required 0", issued_cnt); end
      n_cmp++; if (n_iss - i0 != 16) begin n_err++; $display("FAIL wrap_issues: got %0d, required 16", n_iss - i0); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_stream();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
